// File: rtl/br_recover_ctrl.sv
// Branch-mispredict recovery sequencer: reads the free-list checkpoint, squashes younger ROB entries
// two per cycle, then restores the free-list head and ROB tail. Optional stats: define BR_RECOVER_STATS_EN.
module br_recover_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       ex_mispredict,
    input  logic [4:0] ex_branch_robidx,
    input  logic [4:0] rob_head_in,
    input  logic [4:0] rob_tail_in,
    input  logic [4:0] bs_fl_head_in,
    output logic       bs_rd_en_out,
    output logic [4:0] bs_rd_idx_out,
    output logic [1:0] rob_squash_valid_out,
    output logic [4:0] rob_squash_idxA_out,
    output logic [4:0] rob_squash_idxB_out,
    output logic       fl_restore_en_out,
    output logic [4:0] fl_restore_head_out,
    output logic [4:0] rob_tail_restore_out,
    output logic       stall_out,
    output logic       recover_done_out
`ifdef BR_RECOVER_STATS_EN
    ,
    output logic [15:0] stat_recoveries_out,
    output logic [15:0] stat_squashed_out
`endif
);

    typedef enum logic [1:0] {IDLE, READ, SQUASH, RESTORE} state_t;

    state_t     state_q, state_d;
    logic [4:0] br_idx_q, br_idx_d;
    logic [4:0] walk_q, walk_d;
    logic [4:0] ckpt_q, ckpt_d;

    logic       rd_en_q, rd_en_d;
    logic [4:0] rd_idx_q, rd_idx_d;
    logic [1:0] sq_valid_q, sq_valid_d;
    logic [4:0] sq_a_q, sq_a_d;
    logic [4:0] sq_b_q, sq_b_d;
    logic       fl_en_q, fl_en_d;
    logic [4:0] fl_head_q, fl_head_d;
    logic [4:0] tail_rst_q, tail_rst_d;
    logic       done_q, done_d;
    logic       stall_q;

    logic [4:0] walk_m1;
    logic [4:0] br_p1;
    logic [4:0] br_d_p1;
    logic       slot_b_ok;
    logic [4:0] new_age;
    logic [4:0] cur_age;
    logic       relatch;

    assign walk_m1   = walk_q - 5'd1;
    assign br_p1     = br_idx_q + 5'd1;
    assign br_d_p1   = br_idx_d + 5'd1;
    assign slot_b_ok = (walk_q != br_p1);

    // Ages are distances from the ROB head, so a smaller age means an older instruction.
    assign new_age = ex_branch_robidx - rob_head_in;
    assign cur_age = br_idx_q - rob_head_in;
    assign relatch = ex_mispredict && (state_q != IDLE) && (new_age < cur_age);

    always_comb begin
        state_d  = state_q;
        br_idx_d = br_idx_q;
        walk_d   = walk_q;
        ckpt_d   = ckpt_q;
        case (state_q)
            IDLE: begin
                if (ex_mispredict) begin
                    br_idx_d = ex_branch_robidx;
                    walk_d   = rob_tail_in - 5'd1;
                    state_d  = READ;
                end
            end
            READ: begin
                ckpt_d  = bs_fl_head_in;
                state_d = (walk_q == br_idx_q) ? RESTORE : SQUASH;
            end
            SQUASH: begin
                walk_d = slot_b_ok ? (walk_q - 5'd2) : walk_m1;
                if (!slot_b_ok || (walk_m1 == br_p1)) begin
                    state_d = RESTORE;
                end
            end
            RESTORE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // An older mispredict re-reads its checkpoint; walk keeps going from where it is, so
        // entries already squashed are never revisited.
        if (relatch) begin
            br_idx_d = ex_branch_robidx;
            state_d  = READ;
        end
    end

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_comb begin
        rd_en_d    = (state_d == READ);
        rd_idx_d   = rd_en_d ? br_idx_d : 5'd0;
        sq_valid_d = 2'b00;
        sq_a_d     = 5'd0;
        sq_b_d     = 5'd0;
        if (state_d == SQUASH) begin
            sq_valid_d[0] = 1'b1;
            sq_a_d        = walk_d;
            if (walk_d != br_d_p1) begin
                sq_valid_d[1] = 1'b1;
                sq_b_d        = walk_d - 5'd1;
            end
        end
        fl_en_d    = (state_d == RESTORE);
        fl_head_d  = fl_en_d ? ckpt_d : 5'd0;
        tail_rst_d = fl_en_d ? br_d_p1 : 5'd0;
        done_d     = fl_en_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            br_idx_q   <= 5'd0;
            walk_q     <= 5'd0;
            ckpt_q     <= 5'd0;
            rd_en_q    <= 1'b0;
            rd_idx_q   <= 5'd0;
            sq_valid_q <= 2'b00;
            sq_a_q     <= 5'd0;
            sq_b_q     <= 5'd0;
            fl_en_q    <= 1'b0;
            fl_head_q  <= 5'd0;
            tail_rst_q <= 5'd0;
            done_q     <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            br_idx_q   <= br_idx_d;
            walk_q     <= walk_d;
            ckpt_q     <= ckpt_d;
            rd_en_q    <= rd_en_d;
            rd_idx_q   <= rd_idx_d;
            sq_valid_q <= sq_valid_d;
            sq_a_q     <= sq_a_d;
            sq_b_q     <= sq_b_d;
            fl_en_q    <= fl_en_d;
            fl_head_q  <= fl_head_d;
            tail_rst_q <= tail_rst_d;
            done_q     <= done_d;
            stall_q    <= (state_d != IDLE);
        end
    end

    assign bs_rd_en_out         = rd_en_q;
    assign bs_rd_idx_out        = rd_idx_q;
    assign rob_squash_valid_out = sq_valid_q;
    assign rob_squash_idxA_out  = sq_a_q;
    assign rob_squash_idxB_out  = sq_b_q;
    assign fl_restore_en_out    = fl_en_q;
    assign fl_restore_head_out  = fl_head_q;
    assign rob_tail_restore_out = tail_rst_q;
    assign recover_done_out     = done_q;
    // The front end must stall in the very cycle the mispredict arrives, before the FSM leaves IDLE.
    assign stall_out            = stall_q | (ex_mispredict & ~reset);

`ifdef BR_RECOVER_STATS_EN
    logic [15:0] recov_cnt_q;
    logic [15:0] sq_cnt_q;
    logic [1:0]  sq_n;

    assign sq_n = {1'b0, sq_valid_q[0]} + {1'b0, sq_valid_q[1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            recov_cnt_q <= 16'd0;
            sq_cnt_q    <= 16'd0;
        end else begin
            if (fl_en_q && (recov_cnt_q != 16'hFFFF)) begin
                recov_cnt_q <= recov_cnt_q + 16'd1;
            end
            if (sq_cnt_q > (16'hFFFF - {14'd0, sq_n})) begin
                sq_cnt_q <= 16'hFFFF;
            end else begin
                sq_cnt_q <= sq_cnt_q + {14'd0, sq_n};
            end
        end
    end

    assign stat_recoveries_out = recov_cnt_q;
    assign stat_squashed_out   = sq_cnt_q;
`endif

endmodule

// File: tb/tb_br_recover_ctrl.sv
// Self-checking bench for br_recover_ctrl: table-driven recoveries checked cycle by cycle through an
// expected-output queue, plus hand-built relatch and mid-recovery reset sequences.
module tb_br_recover_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       ex_mispredict;
    logic [4:0] ex_branch_robidx;
    logic [4:0] rob_head_in;
    logic [4:0] rob_tail_in;
    logic [4:0] bs_fl_head_in;
    logic       bs_rd_en_out;
    logic [4:0] bs_rd_idx_out;
    logic [1:0] rob_squash_valid_out;
    logic [4:0] rob_squash_idxA_out;
    logic [4:0] rob_squash_idxB_out;
    logic       fl_restore_en_out;
    logic [4:0] fl_restore_head_out;
    logic [4:0] rob_tail_restore_out;
    logic       stall_out;
    logic       recover_done_out;
`ifdef BR_RECOVER_STATS_EN
    logic [15:0] stat_recoveries_out;
    logic [15:0] stat_squashed_out;
`endif

    always #5 clock = ~clock;

    br_recover_ctrl dut (
        .clock                (clock),
        .reset                (reset),
        .ex_mispredict        (ex_mispredict),
        .ex_branch_robidx     (ex_branch_robidx),
        .rob_head_in          (rob_head_in),
        .rob_tail_in          (rob_tail_in),
        .bs_fl_head_in        (bs_fl_head_in),
        .bs_rd_en_out         (bs_rd_en_out),
        .bs_rd_idx_out        (bs_rd_idx_out),
        .rob_squash_valid_out (rob_squash_valid_out),
        .rob_squash_idxA_out  (rob_squash_idxA_out),
        .rob_squash_idxB_out  (rob_squash_idxB_out),
        .fl_restore_en_out    (fl_restore_en_out),
        .fl_restore_head_out  (fl_restore_head_out),
        .rob_tail_restore_out (rob_tail_restore_out),
        .stall_out            (stall_out),
        .recover_done_out     (recover_done_out)
`ifdef BR_RECOVER_STATS_EN
        ,
        .stat_recoveries_out  (stat_recoveries_out),
        .stat_squashed_out    (stat_squashed_out)
`endif
    );

    // Branch-stack contents: a fixed scramble of the index, so a wrong read index shows up as a wrong head.
    function automatic logic [4:0] ck(input logic [4:0] i);
        return 5'(i * 5'd7 + 5'd3);
    endfunction

    assign bs_fl_head_in = ck(bs_rd_idx_out);

    typedef struct packed {
        logic       rd_en;
        logic [4:0] rd_idx;
        logic [1:0] sqv;
        logic [4:0] a;
        logic [4:0] b;
        logic       fl_en;
        logic [4:0] fl_head;
        logic [4:0] tail_r;
        logic       stall;
        logic       done;
    } obs_t;

    typedef struct {
        logic [4:0] head;
        logic [4:0] tail;
        logic [4:0] idx;
        logic [4:0] exp_tail;
        int         exp_done;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    obs_t expq[$];
    logic stim_mp[64];
    logic [4:0] stim_idx[64];
    logic stim_rst[64];
    int   done_cyc;
    logic [4:0] done_tail;
    vec_t vecs[5];
    int   exp_recov;
    int   exp_sq;

    function automatic obs_t mk(input logic rd_en, input logic [4:0] rd_idx, input logic [1:0] sqv,
                                input logic [4:0] a, input logic [4:0] b, input logic fl_en,
                                input logic [4:0] fl_head, input logic [4:0] tail_r,
                                input logic stall, input logic done);
        obs_t o;
        o.rd_en = rd_en; o.rd_idx = rd_idx; o.sqv = sqv; o.a = a; o.b = b;
        o.fl_en = fl_en; o.fl_head = fl_head; o.tail_r = tail_r; o.stall = stall; o.done = done;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(bs_rd_en_out, bs_rd_idx_out, rob_squash_valid_out, rob_squash_idxA_out,
                  rob_squash_idxB_out, fl_restore_en_out, fl_restore_head_out,
                  rob_tail_restore_out, stall_out, recover_done_out);
    endfunction

    // Reference model of an uninterrupted recovery: one pulse cycle, one read, squash down to idx+1.
    task automatic push_recovery(input logic [4:0] tail, input logic [4:0] idx, output int nsq);
        obs_t o;
        logic [4:0] w;
        nsq = 0;
        expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        expq.push_back(mk(1, idx, 0, 0, 0, 0, 0, 0, 1, 0));
        w = tail - 5'd1;
        for (int n = 0; n < 32 && w != idx; n++) begin
            o = mk(0, 0, 2'b01, w, 0, 0, 0, 0, 1, 0);
            nsq++;
            w = w - 5'd1;
            if (w != idx) begin
                o.sqv[1] = 1'b1;
                o.b = w;
                nsq++;
                w = w - 5'd1;
            end
            expq.push_back(o);
        end
        expq.push_back(mk(0, 0, 0, 0, 0, 1, ck(idx), idx + 5'd1, 1, 1));
        expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic clear_stim();
        for (int k = 0; k < 64; k++) begin
            stim_mp[k] = 1'b0;
            stim_idx[k] = 5'd0;
            stim_rst[k] = 1'b0;
        end
    endtask

    // Apply per-cycle stimulus and compare every cycle against the head of the expected queue.
    task automatic run_seq(input int n);
        obs_t e;
        obs_t g;
        done_cyc = -1;
        done_tail = 5'd0;
        for (int k = 0; k < n; k++) begin
            ex_mispredict = stim_mp[k];
            ex_branch_robidx = stim_idx[k];
            reset = stim_rst[k];
            @(negedge clock);
            g = sample();
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_empty cycle %0d got %h required an expected entry", k, g);
            end else begin
                e = expq.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL cycle_%0d outputs got %h required %h", k, g, e);
                end
            end
            if (g.done === 1'b1 && done_cyc < 0) begin
                done_cyc = k;
                done_tail = g.tail_r;
            end
            @(posedge clock);
            #1;
        end
        ex_mispredict = 1'b0;
        reset = 1'b0;
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover got %0d entries required 0", expq.size());
            expq.delete();
        end
    endtask

    initial begin
        int nsq;
        int len;
        vecs[0] = '{head: 5'd0,  tail: 5'd6,  idx: 5'd2,  exp_tail: 5'd3,  exp_done: 4};
        vecs[1] = '{head: 5'd0,  tail: 5'd3,  idx: 5'd2,  exp_tail: 5'd3,  exp_done: 2};
        vecs[2] = '{head: 5'd28, tail: 5'd2,  idx: 5'd30, exp_tail: 5'd31, exp_done: 4};
        vecs[3] = '{head: 5'd10, tail: 5'd20, idx: 5'd11, exp_tail: 5'd12, exp_done: 6};
        vecs[4] = '{head: 5'd31, tail: 5'd1,  idx: 5'd31, exp_tail: 5'd0,  exp_done: 3};
        exp_recov = 0;
        exp_sq = 0;

        reset = 1'b1;
        ex_mispredict = 1'b0;
        ex_branch_robidx = 5'd0;
        rob_head_in = 5'd0;
        rob_tail_in = 5'd8;
        repeat (2) @(posedge clock);
        #1;
        // Mispredict during reset must not start a recovery.
        ex_mispredict = 1'b1;
        ex_branch_robidx = 5'd4;
        @(negedge clock);
        tests++;
        if (sample() !== obs_t'(0)) begin
            fails++;
            $display("FAIL reset_state got %h required %h", sample(), obs_t'(0));
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        ex_mispredict = 1'b0;
        clear_stim();
        expq.push_back(obs_t'(0));
        expq.push_back(obs_t'(0));
        run_seq(2);
        $display("[TB] reset with mispredict: no recovery started");

        for (int v = 0; v < 5; v++) begin
            rob_head_in = vecs[v].head;
            rob_tail_in = vecs[v].tail;
            clear_stim();
            stim_mp[0] = 1'b1;
            stim_idx[0] = vecs[v].idx;
            push_recovery(vecs[v].tail, vecs[v].idx, nsq);
            exp_recov++;
            exp_sq += nsq;
            len = expq.size();
            run_seq(len);
            tests++;
            if (done_cyc != vecs[v].exp_done) begin
                fails++;
                $display("FAIL vec%0d_done_cycle got %0d required %0d", v, done_cyc, vecs[v].exp_done);
            end
            tests++;
            if (done_tail !== vecs[v].exp_tail) begin
                fails++;
                $display("FAIL vec%0d_tail_restore got %0d required %0d", v, done_tail, vecs[v].exp_tail);
            end
            $display("[TB] vec%0d head=%0d tail=%0d idx=%0d squashed=%0d done_cycle=%0d", v,
                     vecs[v].head, vecs[v].tail, vecs[v].idx, nsq, done_cyc);
        end
`ifdef BR_RECOVER_STATS_EN
        tests++;
        if (stat_recoveries_out !== 16'(exp_recov)) begin
            fails++;
            $display("FAIL stat_recoveries got %0d required %0d", stat_recoveries_out, exp_recov);
        end
        tests++;
        if (stat_squashed_out !== 16'(exp_sq)) begin
            fails++;
            $display("FAIL stat_squashed got %0d required %0d", stat_squashed_out, exp_sq);
        end
`endif

        // Older branch arrives mid-squash; a younger one during the re-read is ignored.
        rob_head_in = 5'd0;
        rob_tail_in = 5'd10;
        clear_stim();
        stim_mp[0] = 1'b1; stim_idx[0] = 5'd7;
        stim_mp[2] = 1'b1; stim_idx[2] = 5'd3;
        stim_mp[3] = 1'b1; stim_idx[3] = 5'd8;
        expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        expq.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 1, 0));
        expq.push_back(mk(0, 0, 2'b11, 9, 8, 0, 0, 0, 1, 0));
        expq.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 1, 0));
        expq.push_back(mk(0, 0, 2'b11, 7, 6, 0, 0, 0, 1, 0));
        expq.push_back(mk(0, 0, 2'b11, 5, 4, 0, 0, 0, 1, 0));
        expq.push_back(mk(0, 0, 0, 0, 0, 1, ck(5'd3), 4, 1, 1));
        expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_seq(8);
        $display("[TB] relatch 7->3 during squash, younger 8 ignored, done_cycle=%0d", done_cyc);

        // Reset in the middle of a squash aborts the recovery with no restore strobe.
        clear_stim();
        stim_mp[0] = 1'b1; stim_idx[0] = 5'd2;
        stim_rst[2] = 1'b1;
        expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        expq.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0));
        expq.push_back(mk(0, 0, 2'b11, 9, 8, 0, 0, 0, 1, 0));
        expq.push_back(obs_t'(0));
        expq.push_back(obs_t'(0));
        expq.push_back(obs_t'(0));
        run_seq(6);
`ifdef BR_RECOVER_STATS_EN
        tests++;
        if (stat_recoveries_out !== 16'd0 || stat_squashed_out !== 16'd0) begin
            fails++;
            $display("FAIL stats_after_reset got %0d/%0d required 0/0", stat_recoveries_out, stat_squashed_out);
        end
`endif
        $display("[TB] reset mid-squash: recovery aborted");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish required completion");
        $fatal(1, "timeout");
    end

endmodule
